// File: rtl/ls_access_if.sv
// ls_access_if -- local-store request/response bus.
//   ls_req    : request strobe (master -> slave)
//   ls_we     : 1 = write, 0 = read
//   ls_addr   : 14-bit quadword address
//   ls_wdata  : 128-bit write data
//   ls_gnt    : request accepted this cycle (slave -> master)
//   ls_rvalid : read data valid (slave -> master)
//   ls_rdata  : 128-bit read data (slave -> master)
interface ls_access_if;
    logic         ls_req;
    logic         ls_we;
    logic [13:0]  ls_addr;
    logic [127:0] ls_wdata;
    logic         ls_gnt;
    logic         ls_rvalid;
    logic [127:0] ls_rdata;

    modport master (
        output ls_req, ls_we, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata
    );

    modport slave (
        input  ls_req, ls_we, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata
    );
endinterface

// File: rtl/ls_access.sv
// ls_access -- MEM stage of the pipeline: issues local-store accesses for
// loads/stores, stalls the pipe until they complete, resolves branches and
// registers the writeback slot.
// Ports:
//   clk, reset (async, active-low)
//   valid_in, memRead_in, memWrite_in, mem_to_reg_in, regWrite_enable_in,
//   branch_in, zero_in, JumpPC_in, ALUResult_in, ReadDataC_in, RegisterRT_in
//                              : EX/MEM slot contents
//   stall_out                  : hold EX/MEM and earlier stages
//   pc_src_out, JumpPC_out     : branch resolution
//   ls                         : local-store bus (master side)
//   wb_valid, wb_regWrite, wb_data, wb_rt : registered writeback slot
//   err_out                    : sticky local-store timeout flag
module ls_access (
    input  logic           clk,
    input  logic           reset,
    input  logic           valid_in,
    input  logic           memRead_in,
    input  logic           memWrite_in,
    input  logic           mem_to_reg_in,
    input  logic           regWrite_enable_in,
    input  logic           branch_in,
    input  logic           zero_in,
    input  logic [10:0]    JumpPC_in,
    input  logic [127:0]   ALUResult_in,
    input  logic [127:0]   ReadDataC_in,
    input  logic [6:0]     RegisterRT_in,
    output logic           stall_out,
    output logic           pc_src_out,
    output logic [10:0]    JumpPC_out,
    ls_access_if.master    ls,
    output logic           wb_valid,
    output logic           wb_regWrite,
    output logic [127:0]   wb_data,
    output logic [6:0]     wb_rt,
    output logic           err_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         err_q, err_d;
    logic         wb_valid_q, wb_valid_d;
    logic         wb_regwrite_q, wb_regwrite_d;
    logic [127:0] wb_data_q, wb_data_d;
    logic [6:0]   wb_rt_q, wb_rt_d;

    logic         mem_op_s;
    logic         done_now_s;
    logic         timeout_s;
    logic         complete_s;

    assign mem_op_s = valid_in & (memRead_in | memWrite_in);

    // Access FSM and timeout counter next-state. The write/read decision in
    // REQ uses memWrite_in directly: inputs are held while stalled, and a
    // read+write combination is treated as a write.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_now_s = 1'b0;
        timeout_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op_s) begin
                    state_d = S_REQ;
                    cnt_d   = 4'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (ls.ls_gnt) begin
                    if (memWrite_in) begin
                        state_d    = S_IDLE;
                        done_now_s = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'd0;
                    end
                end else if (cnt_q == 4'd15) begin
                    state_d    = S_IDLE;
                    done_now_s = 1'b1;
                    timeout_s  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (ls.ls_rvalid) begin
                    state_d    = S_IDLE;
                    done_now_s = 1'b1;
                end else if (cnt_q == 4'd15) begin
                    state_d    = S_IDLE;
                    done_now_s = 1'b1;
                    timeout_s  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // A slot completes when it is a non-memory instruction or its access ends.
    assign complete_s = (valid_in & ~mem_op_s) | done_now_s;

    // Writeback slot next-state; a timed-out access retires with no register
    // write and zero data so the stale load value never reaches RT.
    always_comb begin
        err_d         = err_q | timeout_s;
        wb_valid_d    = 1'b0;
        wb_regwrite_d = 1'b0;
        wb_data_d     = wb_data_q;
        wb_rt_d       = wb_rt_q;
        if (complete_s) begin
            wb_valid_d = 1'b1;
            wb_rt_d    = RegisterRT_in;
            if (timeout_s) begin
                wb_regwrite_d = 1'b0;
                wb_data_d     = 128'd0;
            end else begin
                wb_regwrite_d = regWrite_enable_in;
                wb_data_d     = mem_to_reg_in ? ls.ls_rdata : ALUResult_in;
            end
        end else begin
            wb_valid_d    = 1'b0;
            wb_regwrite_d = 1'b0;
        end
    end

    // State, counter, error flag and writeback registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            err_q         <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_data_q     <= 128'd0;
            wb_rt_q       <= 7'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_q         <= err_d;
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_data_q     <= wb_data_d;
            wb_rt_q       <= wb_rt_d;
        end
    end

    // Stall is forced low in reset so the front of the pipe is not frozen.
    assign stall_out  = reset & mem_op_s & ~done_now_s;
    assign pc_src_out = valid_in & branch_in & zero_in & ~stall_out;
    assign JumpPC_out = JumpPC_in;

    assign ls.ls_req   = (state_q == S_REQ);
    assign ls.ls_we    = (state_q == S_REQ) & memWrite_in;
    assign ls.ls_addr  = ALUResult_in[17:4];
    assign ls.ls_wdata = ReadDataC_in;

    assign wb_valid    = wb_valid_q;
    assign wb_regWrite = wb_regwrite_q;
    assign wb_data     = wb_data_q;
    assign wb_rt       = wb_rt_q;
    assign err_out     = err_q;

endmodule

// File: tb/tb_ls_access.sv
module tb_ls_access;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in, memRead_in, memWrite_in, mem_to_reg_in;
    logic         regWrite_enable_in, branch_in, zero_in;
    logic [10:0]  JumpPC_in;
    logic [127:0] ALUResult_in, ReadDataC_in;
    logic [6:0]   RegisterRT_in;
    logic         stall_out, pc_src_out;
    logic [10:0]  JumpPC_out;
    logic         wb_valid, wb_regWrite, err_out;
    logic [127:0] wb_data;
    logic [6:0]   wb_rt;

    int vec_cnt = 0;
    int err_cnt = 0;

    ls_access_if lsif ();

    ls_access dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .memRead_in(memRead_in), .memWrite_in(memWrite_in),
        .mem_to_reg_in(mem_to_reg_in), .regWrite_enable_in(regWrite_enable_in),
        .branch_in(branch_in), .zero_in(zero_in), .JumpPC_in(JumpPC_in),
        .ALUResult_in(ALUResult_in), .ReadDataC_in(ReadDataC_in),
        .RegisterRT_in(RegisterRT_in),
        .stall_out(stall_out), .pc_src_out(pc_src_out), .JumpPC_out(JumpPC_out),
        .ls(lsif),
        .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_data(wb_data),
        .wb_rt(wb_rt), .err_out(err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         valid, rd, wr, m2r, rw, br, zero;
        logic [10:0]  jpc;
        logic [127:0] alu;
        logic [127:0] rdata;
        logic [6:0]   rt;
        logic         e_stall, e_pc_src, e_wb_valid, e_wb_rw;
        logic [127:0] e_wb_data;
        logic [6:0]   e_wb_rt;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; memRead_in = 1'b0; memWrite_in = 1'b0; mem_to_reg_in = 1'b0;
        regWrite_enable_in = 1'b0; branch_in = 1'b0; zero_in = 1'b0;
        JumpPC_in = 11'd0; ALUResult_in = 128'd0; ReadDataC_in = 128'd0;
        RegisterRT_in = 7'd0;
        lsif.ls_gnt = 1'b0; lsif.ls_rvalid = 1'b0; lsif.ls_rdata = 128'd0;
    endtask

    task automatic mem_inputs(input logic wr, input logic m2r, input logic [127:0] alu,
                              input logic [127:0] wd, input logic [6:0] rt);
        valid_in = 1'b1; memRead_in = ~wr; memWrite_in = wr; mem_to_reg_in = m2r;
        regWrite_enable_in = 1'b1; branch_in = 1'b0; zero_in = 1'b0;
        ALUResult_in = alu; ReadDataC_in = wd; RegisterRT_in = rt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // valid, rd, wr, m2r, rw, br, zero, jpc, alu, rdata, rt | stall, pc, wbv, wbrw, wbdata, wbrt
        vecs[0] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 11'd0,   {16{8'hA5}}, 128'd0, 7'd5,
                    1'b0,1'b0,1'b1,1'b1, {16{8'hA5}}, 7'd5};
        vecs[1] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 11'd0,   {16{8'hFF}}, 128'd0, 7'd9,
                    1'b0,1'b0,1'b0,1'b0, {16{8'hA5}}, 7'd5};
        vecs[2] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 11'h3A5, 128'h10,     128'd0, 7'd2,
                    1'b0,1'b1,1'b1,1'b0, 128'h10, 7'd2};
        vecs[3] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 11'h155, 128'h20,     128'd0, 7'd3,
                    1'b0,1'b0,1'b1,1'b0, 128'h20, 7'd3};
        vecs[4] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 11'h2AA, 128'h30,     128'd0, 7'd4,
                    1'b0,1'b0,1'b0,1'b0, 128'h20, 7'd3};
        vecs[5] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 11'd0,   128'h55,  128'hDEAD, 7'd7,
                    1'b0,1'b0,1'b1,1'b1, 128'hDEAD, 7'd7};
        vecs[6] = '{1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 11'h7FF, 128'h66,  128'hDEAD, 7'd8,
                    1'b0,1'b0,1'b1,1'b1, 128'h66, 7'd8};

        // Reset: mem_op and a taken branch presented while reset is low.
        idle_inputs();
        reset = 1'b0;
        valid_in = 1'b1; memRead_in = 1'b1; branch_in = 1'b1; zero_in = 1'b1;
        JumpPC_in = 11'h123;
        #12;
        chk("rst_stall", stall_out, 1'b0);
        chk("rst_pc_src", pc_src_out, 1'b1);
        chk("rst_jpc", JumpPC_out, 11'h123);
        chk("rst_ls_req", lsif.ls_req, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_rw", wb_regWrite, 1'b0);
        chk("rst_wb_data", wb_data, 128'd0);
        chk("rst_wb_rt", wb_rt, 7'd0);
        chk("rst_err", err_out, 1'b0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;

        // Single-cycle table; stray gnt/rvalid must be ignored in IDLE.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            valid_in = vecs[i].valid; memRead_in = vecs[i].rd; memWrite_in = vecs[i].wr;
            mem_to_reg_in = vecs[i].m2r; regWrite_enable_in = vecs[i].rw;
            branch_in = vecs[i].br; zero_in = vecs[i].zero; JumpPC_in = vecs[i].jpc;
            ALUResult_in = vecs[i].alu; RegisterRT_in = vecs[i].rt;
            lsif.ls_rdata = vecs[i].rdata; lsif.ls_gnt = 1'b1; lsif.ls_rvalid = 1'b1;
            #1;
            chk($sformatf("v%0d_stall", i), stall_out, vecs[i].e_stall);
            chk($sformatf("v%0d_pc_src", i), pc_src_out, vecs[i].e_pc_src);
            chk($sformatf("v%0d_jpc", i), JumpPC_out, vecs[i].jpc);
            chk($sformatf("v%0d_ls_req", i), lsif.ls_req, 1'b0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_wb_valid", i), wb_valid, vecs[i].e_wb_valid);
            chk($sformatf("v%0d_wb_rw", i), wb_regWrite, vecs[i].e_wb_rw);
            chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_wb_data);
            chk($sformatf("v%0d_wb_rt", i), wb_rt, vecs[i].e_wb_rt);
        end

        // Store: IDLE + 2 REQ cycles stalled, grant in the third REQ cycle.
        @(negedge clk);
        idle_inputs();
        mem_inputs(1'b1, 1'b0, 128'h130, 128'hCAFE, 7'd11);
        for (int c = 0; c < 4; c++) begin
            if (c != 0) @(negedge clk);
            lsif.ls_gnt = (c == 3);
            #1;
            chk($sformatf("st%0d_stall", c), stall_out, c < 3);
            chk($sformatf("st%0d_ls_req", c), lsif.ls_req, c != 0);
            if (c != 0) begin
                chk($sformatf("st%0d_ls_we", c), lsif.ls_we, 1'b1);
                chk($sformatf("st%0d_ls_addr", c), lsif.ls_addr, 14'h013);
                chk($sformatf("st%0d_ls_wdata", c), lsif.ls_wdata, 128'hCAFE);
            end
            @(posedge clk); #1;
        end
        chk("st_wb_valid", wb_valid, 1'b1);
        chk("st_wb_rw", wb_regWrite, 1'b1);
        chk("st_wb_data", wb_data, 128'h130);
        chk("st_wb_rt", wb_rt, 7'd11);

        // Load presented right after the store completes: grant at once,
        // read data three cycles later.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) mem_inputs(1'b0, 1'b1, 128'h240, 128'd0, 7'd20);
            lsif.ls_gnt    = (c == 1);
            lsif.ls_rvalid = (c == 4);
            lsif.ls_rdata  = (c == 4) ? 128'h1234 : 128'hBAD;
            #1;
            chk($sformatf("ld%0d_stall", c), stall_out, c < 4);
            chk($sformatf("ld%0d_ls_req", c), lsif.ls_req, c == 1);
            if (c == 1) begin
                chk("ld_ls_we", lsif.ls_we, 1'b0);
                chk("ld_ls_addr", lsif.ls_addr, 14'h024);
            end
            @(posedge clk); #1;
            if (c < 4) chk($sformatf("ld%0d_wb_valid", c), wb_valid, 1'b0);
        end
        chk("ld_wb_valid", wb_valid, 1'b1);
        chk("ld_wb_rw", wb_regWrite, 1'b1);
        chk("ld_wb_data", wb_data, 128'h1234);
        chk("ld_wb_rt", wb_rt, 7'd20);

        // Timeout: no grant; 16th REQ cycle (counter = 15) ends the access.
        @(negedge clk);
        idle_inputs();
        mem_inputs(1'b0, 1'b1, 128'h500, 128'd0, 7'd30);
        lsif.ls_rdata = 128'hBEEF;
        for (int k = 0; k < 17; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk($sformatf("to%0d_stall", k), stall_out, k < 16);
            chk($sformatf("to%0d_err", k), err_out, 1'b0);
            @(posedge clk); #1;
        end
        chk("to_err_set", err_out, 1'b1);
        chk("to_wb_valid", wb_valid, 1'b1);
        chk("to_wb_rw", wb_regWrite, 1'b0);
        chk("to_wb_data", wb_data, 128'd0);
        chk("to_wb_rt", wb_rt, 7'd30);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("to_ls_req_after", lsif.ls_req, 1'b0);
        @(posedge clk); #1;
        chk("to_err_sticky", err_out, 1'b1);
        chk("to_wb_valid_after", wb_valid, 1'b0);

        // Reset while in WAIT.
        @(negedge clk);
        mem_inputs(1'b0, 1'b1, 128'h600, 128'd0, 7'd40);
        @(negedge clk);
        lsif.ls_gnt = 1'b1;
        @(negedge clk);
        lsif.ls_gnt = 1'b0;
        #1;
        chk("rw_wait_stall", stall_out, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk("rw_stall", stall_out, 1'b0);
        chk("rw_ls_req", lsif.ls_req, 1'b0);
        chk("rw_wb_valid", wb_valid, 1'b0);
        chk("rw_wb_rt", wb_rt, 7'd0);
        chk("rw_err", err_out, 1'b0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        lsif.ls_rvalid = 1'b1;
        @(posedge clk); #1;
        chk("rw_late_rvalid_wb", wb_valid, 1'b0);
        // A new load with rvalid high: stalls in IDLE, so the FSM is not in WAIT.
        @(negedge clk);
        mem_inputs(1'b0, 1'b1, 128'h700, 128'd0, 7'd41);
        #1;
        chk("rw_idle_stall", stall_out, 1'b1);
        chk("rw_idle_ls_req", lsif.ls_req, 1'b0);
        @(negedge clk);
        lsif.ls_rvalid = 1'b0;
        #1;
        chk("rr_ls_req_on", lsif.ls_req, 1'b1);
        // Reset while in REQ drops the request immediately.
        #1;
        reset = 1'b0;
        #1;
        chk("rr_ls_req_off", lsif.ls_req, 1'b0);
        chk("rr_stall", stall_out, 1'b0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rr_wb_valid", wb_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
